// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus widths and the master's state encoding
package apb_pkg;
   localparam int AW = 32;
   localparam int DW = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr+1 with wrap-around
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);
   logic [IW-1:0] c;
   always_comb begin
      idx = ptr;
      c = ptr;
      for (int i = NUM_REQ; i >= 1; i--) begin
         c = IW'((int'(ptr) + i) % NUM_REQ);
         if (req[c]) idx = c;
      end
      gnt = |req ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one slave among NUM_REQ requesters,
// with a bounded ACCESS phase that forces an error completion on timeout
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   input  logic [NUM_REQ-1:0]    i_req_write,
   input  logic [NUM_REQ*AW-1:0] i_req_addr,
   input  logic [NUM_REQ*DW-1:0] i_req_wdata,
   output logic [NUM_REQ-1:0]    o_req_ready,
   output logic [NUM_REQ-1:0]    o_rsp_valid,
   output logic [DW-1:0]         o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [AW-1:0]         PADDR,
   output logic                  PWRITE,
   output logic [DW-1:0]         PWDATA,
   output logic                  PSELx,
   output logic                  PENABLE,
   input  logic [DW-1:0]         PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   state_t state, state_d;
   logic [IW-1:0] ptr, ptr_d, gidx;
   logic [CW-1:0] cnt, cnt_d;
   logic [NUM_REQ-1:0] gnt, ready_d, rsp_valid_d;
   logic [AW-1:0] paddr_d;
   logic [DW-1:0] pwdata_d, rdata_d;
   logic pwrite_d, psel_d, penable_d, err_d, done;
   logic [AW-1:0] addr_a [NUM_REQ];
   logic [DW-1:0] wdata_a [NUM_REQ];
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign addr_a[k] = i_req_addr[AW*k +: AW];
      assign wdata_a[k] = i_req_wdata[DW*k +: DW];
   end
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(i_req_valid), .ptr(ptr), .gnt(gnt), .idx(gidx));
   // PREADY takes precedence over the timeout when both land in the same cycle
   assign done = PREADY || cnt == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_d = state;
      ptr_d = ptr;
      cnt_d = cnt;
      paddr_d = PADDR;
      pwrite_d = PWRITE;
      pwdata_d = PWDATA;
      psel_d = PSELx;
      penable_d = PENABLE;
      ready_d = '0;
      rsp_valid_d = '0;
      rdata_d = o_rsp_rdata;
      err_d = o_rsp_err;
      case (state)
         IDLE: if (|i_req_valid) begin
            state_d = SETUP;
            ptr_d = gidx;
            paddr_d = addr_a[gidx];
            pwrite_d = i_req_write[gidx];
            pwdata_d = wdata_a[gidx];
            psel_d = 1'b1;
            penable_d = 1'b0;
            ready_d = gnt;
         end
         SETUP: begin
            state_d = ACCESS;
            penable_d = 1'b1;
            cnt_d = '0;
         end
         ACCESS: if (done) begin
            state_d = IDLE;
            psel_d = 1'b0;
            penable_d = 1'b0;
            rsp_valid_d = NUM_REQ'(1) << ptr;
            rdata_d = (PREADY && !PWRITE) ? PRDATA : '0;
            err_d = PREADY ? PSLVERR : 1'b1;
         end else cnt_d = cnt + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
         ptr <= IW'(NUM_REQ - 1);
         cnt <= '0;
         PADDR <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PSELx <= 1'b0;
         PENABLE <= 1'b0;
         o_req_ready <= '0;
         o_rsp_valid <= '0;
         o_rsp_rdata <= '0;
         o_rsp_err <= 1'b0;
      end else begin
         state <= state_d;
         ptr <= ptr_d;
         cnt <= cnt_d;
         PADDR <= paddr_d;
         PWRITE <= pwrite_d;
         PWDATA <= pwdata_d;
         PSELx <= psel_d;
         PENABLE <= penable_d;
         o_req_ready <= ready_d;
         o_rsp_valid <= rsp_valid_d;
         o_rsp_rdata <= rdata_d;
         o_rsp_err <= err_d;
      end
   end
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: randomized requesters and a small memory slave checked cycle by cycle
// against a transaction-level model, plus directed scenarios with literal expectations
module tb_apb_rr_master;
   localparam int N = 4;
   localparam int T = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] req_valid = '0, req_write = '0;
   logic [N*32-1:0] req_addr = '0, req_wdata = '0;
   logic [N-1:0] req_ready, rsp_valid;
   logic [31:0] rsp_rdata, paddr, pwdata;
   logic rsp_err, pwrite, psel, penable;
   logic [31:0] prdata = '0;
   logic pready = 1'b0, pslverr = 1'b0;
   always #5 clk = ~clk;
   apb_rr_master #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSELx(psel), .PENABLE(penable),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );
   int pass_cnt = 0, total = 0;
   logic [31:0] mem [16];
   bit m_busy = 0, m_wr = 0, was_rst = 0, rnd_mode = 0, refill = 0;
   logic [1:0] m_g = '0, m_last = 2'(N - 1);
   int m_acc = 0, next_wait = 1, wait_n = 1, acc = 0, a = 0;
   logic [N-1:0] e_ready = '0, e_rsp = '0;
   logic e_psel = 0, e_pen = 0, e_pwrite = 0, e_err = 0;
   logic [31:0] e_paddr = '0, e_pwdata = '0, e_rdata = '0;
   int gq[$];
   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   // Transaction view: grant, one SETUP cycle, ACCESS cycles numbered from 1, then a response cycle
   task automatic model_edge();
      e_ready = '0;
      e_rsp = '0;
      was_rst = rst;
      if (rst) begin
         m_busy = 0; m_last = 2'(N - 1);
         e_psel = 0; e_pen = 0; e_paddr = '0; e_pwrite = 0; e_pwdata = '0; e_rdata = '0; e_err = 0;
      end else if (!m_busy) begin
         if (|req_valid) begin
            for (int i = N; i >= 1; i--) if (req_valid[2'((int'(m_last) + i) % N)]) m_g = 2'((int'(m_last) + i) % N);
            m_last = m_g; m_busy = 1; m_acc = 0; m_wr = req_write[m_g];
            e_ready = N'(1) << m_g; e_psel = 1; e_pen = 0;
            e_paddr = req_addr[32*m_g +: 32]; e_pwrite = m_wr; e_pwdata = req_wdata[32*m_g +: 32];
         end
      end else if (m_acc == 0) begin
         m_acc = 1; e_pen = 1;
      end else if (pready || m_acc == T) begin
         m_busy = 0; e_psel = 0; e_pen = 0; e_rsp = N'(1) << m_g;
         e_rdata = (pready && !m_wr) ? prdata : 32'h0;
         e_err = pready ? pslverr : 1'b1;
      end else m_acc++;
      if (!rst && pready && psel && penable && pwrite) mem[paddr[3:0]] = pwdata;
   endtask
   task automatic compare();
      chk("req_ready", 96'(req_ready), 96'(e_ready));
      chk("rsp_valid", 96'(rsp_valid), 96'(e_rsp));
      chk("psel_penable", 96'({psel, penable}), 96'({e_psel, e_pen}));
      if (e_psel || was_rst) chk("apb_payload", 96'({paddr, pwrite, pwdata}), 96'({e_paddr, e_pwrite, e_pwdata}));
      if (|e_rsp || was_rst) chk("rsp_data", 96'({rsp_rdata, rsp_err}), 96'({e_rdata, e_err}));
      for (int k = 0; k < N; k++) if (req_ready[k]) gq.push_back(k);
   endtask
   task automatic new_req(input int k, input bit w, input logic [31:0] ad, input logic [31:0] d);
      req_valid[k] = 1'b1; req_write[k] = w; req_addr[32*k +: 32] = ad; req_wdata[32*k +: 32] = d;
   endtask
   task automatic drive_next();
      int r;
      for (int k = 0; k < N; k++) begin
         if (req_ready[k]) req_valid[k] = 1'b0;
         if ((req_ready[k] && refill) || (rnd_mode && !req_valid[k] && $urandom_range(0, 9) < 3))
            new_req(k, 1'($urandom), 32'($urandom_range(0, 15)), $urandom);
      end
      if (psel && !penable) begin
         acc = 0;
         r = $urandom_range(0, 9);
         wait_n = !rnd_mode ? next_wait : r < 7 ? r % 4 + 1 : r == 7 ? T - 1 : r == 8 ? T : T + 4;
      end
      if (psel && penable) begin
         acc++;
         pready = (acc == wait_n);
         prdata = pwrite ? $urandom : mem[paddr[3:0]];
         pslverr = pready ? (paddr[3:0] == 4'd9) : 1'($urandom);
      end else begin
         pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
      if (rnd_mode) rst = ($urandom_range(0, 599) == 0);
   endtask
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
      drive_next();
   endtask
   task automatic wait_rsp(input string nm, output int n_acc);
      int n;
      n_acc = 0;
      for (n = 0; n < 100; n++) begin
         step();
         if (psel && penable) n_acc++;
         if (|rsp_valid) break;
      end
      if (n == 100) begin
         total++;
         $display("FAIL %s: no response within 100 cycles", nm);
      end
   endtask
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();
      new_req(1, 1, 32'd3, 32'hDEADBEEF); next_wait = 2;
      step(); chk("t2_setup", 96'({psel, penable}), 96'(2'b10)); chk("t2_ready", 96'(req_ready), 96'(4'b0010));
      step(); chk("t2_access1", 96'({psel, penable}), 96'(2'b11));
      step(); chk("t2_access2", 96'({psel, penable}), 96'(2'b11));
      step(); chk("t2_done", 96'({psel, penable, rsp_valid, rsp_err}), 96'({2'b00, 4'b0010, 1'b0}));
      step();
      new_req(2, 0, 32'd3, 32'h0); next_wait = 1;
      wait_rsp("t3_wait", a);
      chk("t3_rsp", 96'({rsp_valid, rsp_rdata}), 96'({4'b0100, 32'hDEADBEEF}));
      step();
      new_req(0, 0, 32'd9, 32'h0);
      wait_rsp("t5_wait", a);
      chk("t5_err", 96'({rsp_valid, rsp_err}), 96'({4'b0001, 1'b1}));
      step();
      new_req(3, 0, 32'd5, 32'h0); next_wait = 1000;
      wait_rsp("t6_wait", a);
      chk("t6_len", 96'(a), 96'(T));
      chk("t6_rsp", 96'({psel, rsp_valid, rsp_rdata, rsp_err}), 96'({1'b0, 4'b1000, 32'h0, 1'b1}));
      step();
      new_req(1, 1, 32'd7, 32'h12345678);
      repeat (3) step();
      chk("t1_in_access", 96'({psel, penable}), 96'(2'b11));
      rst = 1'b1;
      repeat (3) begin
         step();
         chk("t1_reset", 96'({psel, penable, req_ready, rsp_valid}), 96'(0));
      end
      rst = 1'b0;
      repeat (5) begin
         step();
         chk("t1_no_rsp", 96'(rsp_valid), 96'(0));
      end
      gq.delete();
      for (int k = 0; k < N; k++) new_req(k, 1'(k), 32'(k), 32'($urandom));
      refill = 1; next_wait = 1;
      for (int n = 0; n < 300 && gq.size() < 8; n++) step();
      refill = 0;
      chk("t4_count", 96'(gq.size() >= 8), 96'(1));
      for (int i = 0; i < 8 && i < gq.size(); i++) chk("t4_grant", 96'(gq[i]), 96'(i % 4));
      repeat (100) step();
      rnd_mode = 1;
      repeat (4000) step();
      rnd_mode = 0;
      rst = 1'b0;
      repeat (2) step();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave (the team's memory-mapped register slave) among NUM_REQ local requesters.
- Accepts simple valid/ready transaction requests and runs the APB IDLE→SETUP→ACCESS protocol.
- Waits for PREADY, with a bounded timeout, then returns the read data and error status to the granted requester.
- Sits between the internal command sources and the APB bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before forced error completion (≥2).

Ports:
- i_clk  in  1  system/APB clock
- i_reset  in  1  synchronous reset, active-high
- i_req_valid  in  NUM_REQ  per-requester request pending
- i_req_write  in  NUM_REQ  per-requester 1=write, 0=read
- i_req_addr  in  NUM_REQ*32  packed addresses; requester k uses bits [32k+31:32k]
- i_req_wdata  in  NUM_REQ*32  packed write data, same packing
- o_req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: response available
- o_rsp_rdata  out  32  read data (shared, qualified by o_rsp_valid)
- o_rsp_err  out  1  slave error or timeout (qualified by o_rsp_valid)
- PADDR  out  32  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- All outputs are registered. On reset: state=IDLE, PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, rr pointer=NUM_REQ-1 (so requester 0 has highest priority first), timeout counter=0.
- Reset mid-transfer aborts immediately. No response is issued for an aborted transfer.
- IDLE:
  - If any i_req_valid is set, grant g = first set bit searching from (ptr+1) mod NUM_REQ upward, with wrap.
  - Latch addr, write and wdata of g. Set ptr=g.
  - Next cycle: state=SETUP, PSELx=1, PENABLE=0, o_req_ready[g]=1 for that one cycle.
- SETUP: exactly one cycle. Next state is ACCESS with PENABLE=1, PSELx=1, and the timeout counter cleared.
- ACCESS:
  - PADDR, PWRITE and PWDATA are held stable.
  - When PREADY=1 is sampled: next cycle o_rsp_valid[g]=1, o_rsp_rdata=PRDATA (reads) or 0 (writes), o_rsp_err=PSLVERR. PSELx=0, PENABLE=0, state=IDLE.
  - When PREADY=0: the counter increments. If the counter equals TIMEOUT_CYCLES-1 while PREADY=0, the transfer completes with o_rsp_err=1 and o_rsp_rdata=0, and the bus returns to IDLE.
  - PREADY and timeout in the same cycle: PREADY wins.
- i_req_* are ignored outside IDLE.
  - A requester holds valid and payload stable until it sees its o_req_ready pulse.
  - After the pulse it drops valid or presents a new request.
- Minimum transfer: accept edge → SETUP (1) → ACCESS (≥1) → response pulse. IDLE lasts ≥1 cycle between transfers (APB idle).
- Fairness: with all requesters valid continuously, grants cycle 0,1,..,NUM_REQ-1,0,… A single valid requester is granted every transfer.
- At most one bit of o_req_ready, and at most one bit of o_rsp_valid, is set per cycle.
- PREADY and PSLVERR are not acted on outside ACCESS.

Decomposition:
- Shared package apb_pkg:
  - state encoding localparams IDLE=0, SETUP=1, ACCESS=2
  - APB data/address width constant (32)
- Sub-module rr_arbiter:
  - NUM_REQ request vector plus pointer in; one-hot grant and index out.
  - Combinational with wrap-around search.
  - The pointer register lives in apb_rr_master.

Test Plan:
- Reset held 3 cycles mid-ACCESS → all outputs at reset values the next cycle, no o_rsp_valid, ptr=NUM_REQ-1.
- Req1 write addr=3 wdata=0xDEADBEEF, slave PREADY after 2 ACCESS cycles → o_req_ready[1] in SETUP, PSELx/PENABLE sequence 10→11→11→00, o_rsp_valid[1]=1, err=0.
- Req2 read addr=3 (after the above), PRDATA=0xDEADBEEF with PREADY → o_rsp_valid[2]=1, o_rsp_rdata=0xDEADBEEF.
- All four valid continuously for 8 transfers → grant order 0,1,2,3,0,1,2,3.
- Read addr=9, slave returns PSLVERR=1 with PREADY → o_rsp_err=1.
- PREADY held 0 → completion after exactly TIMEOUT_CYCLES ACCESS cycles with o_rsp_err=1, o_rsp_rdata=0, PSELx=0.
